// File: rtl/synth_pkg.sv
// synth_pkg: shared sizes and FSM encoding for the voice phase sequencer
package synth_pkg;
  localparam int NUM_BITS = 32;
  localparam int NUM_CHAN = 16;
  localparam int CHAN_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/chan_reg_file.sv
// chan_reg_file: per-channel tuning word and phase storage, read and accumulated at the scan index
module chan_reg_file #(
  parameter int NUM_BITS = synth_pkg::NUM_BITS,
  parameter int NUM_CHAN = synth_pkg::NUM_CHAN,
  parameter int CHAN_W = synth_pkg::CHAN_W
) (
  input  logic clk,
  input  logic rst,
  input  logic [CHAN_W-1:0] idx_i,
  input  logic acc_we_i,
  input  logic [NUM_BITS-1:0] acc_val_i,
  input  logic ev_we_i,
  input  logic [CHAN_W-1:0] ev_idx_i,
  input  logic [NUM_BITS-1:0] ev_tw_i,
  output logic [NUM_BITS-1:0] tw_o,
  output logic [NUM_BITS-1:0] phase_o
);
  logic [NUM_BITS-1:0] tw_q [NUM_CHAN];
  logic [NUM_BITS-1:0] phase_q [NUM_CHAN];
  assign tw_o = tw_q[idx_i];
  assign phase_o = phase_q[idx_i];
  // the note-event write comes last so a phase clear beats accumulation on the same channel
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        tw_q[i] <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      if (acc_we_i) phase_q[idx_i] <= acc_val_i;
      if (ev_we_i) begin
        tw_q[ev_idx_i] <= ev_tw_i;
        phase_q[ev_idx_i] <= '0;
      end
    end
  end
endmodule

// File: rtl/voice_phase_sequencer.sv
// voice_phase_sequencer: per-sample scan over all voice channels, accumulating each channel's phase
module voice_phase_sequencer #(
  parameter int NUM_BITS = synth_pkg::NUM_BITS,
  parameter int NUM_CHAN = synth_pkg::NUM_CHAN
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic note_on,
  input  logic note_off,
  input  logic [synth_pkg::CHAN_W-1:0] note_chan,
  input  logic [NUM_BITS-1:0] note_tuning,
  input  logic [NUM_BITS-1:0] modulated_tuning_word,
  output logic [NUM_CHAN-1:0] curr_note,
  output logic [NUM_CHAN-1:0] acc_en,
  output logic [NUM_CHAN-1:0] note_enable,
  output logic [NUM_BITS-1:0] tuning_word,
  output logic [NUM_BITS-1:0] phase_out,
  output logic phase_valid,
  output logic [synth_pkg::CHAN_W-1:0] phase_chan,
  output logic busy,
  output logic frame_done,
  output logic overrun
);
  import synth_pkg::*;
  state_t state_q, state_d;
  logic [CHAN_W-1:0] k_q, k_d, pchan_q;
  logic [NUM_CHAN-1:0] en_q, en_d;
  logic [NUM_BITS-1:0] tw_rd, ph_rd, phase_d, phase_q;
  logic pvalid_q, ov_q, scan, chan_ok, ev_we, clr;
  assign scan = state_q == SCAN;
  assign chan_ok = 32'(note_chan) < 32'(NUM_CHAN);
  assign ev_we = note_on && chan_ok;
  assign clr = ev_we && scan && note_chan == k_q;
  assign phase_d = clr ? '0 : ph_rd + modulated_tuning_word;
  assign curr_note = scan ? NUM_CHAN'(1) << k_q : '0;
  assign acc_en = curr_note;
  assign tuning_word = scan ? tw_rd : '0;
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign note_enable = en_q;
  assign phase_out = phase_q;
  assign phase_chan = pchan_q;
  assign phase_valid = pvalid_q;
  assign overrun = ov_q;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    case (state_q)
      IDLE: if (sample_tick) begin
        state_d = SCAN;
        k_d = '0;
      end
      SCAN: begin
        k_d = k_q + CHAN_W'(1);
        if (k_q == CHAN_W'(NUM_CHAN - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // note_on is applied after note_off so it wins on a same-channel collision
  always_comb begin
    en_d = en_q;
    if (note_off && chan_ok) en_d[note_chan] = 1'b0;
    if (ev_we) en_d[note_chan] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      en_q <= '0;
      phase_q <= '0;
      pchan_q <= '0;
      pvalid_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      en_q <= en_d;
      pvalid_q <= scan;
      if (scan) begin
        phase_q <= phase_d;
        pchan_q <= k_q;
      end
      if (sample_tick && busy) ov_q <= 1'b1;
    end
  end
  chan_reg_file #(.NUM_BITS(NUM_BITS), .NUM_CHAN(NUM_CHAN), .CHAN_W(CHAN_W)) u_regs (
    .clk(clk),
    .rst(rst),
    .idx_i(k_q),
    .acc_we_i(scan),
    .acc_val_i(phase_d),
    .ev_we_i(ev_we),
    .ev_idx_i(note_chan),
    .ev_tw_i(note_tuning),
    .tw_o(tw_rd),
    .phase_o(ph_rd)
  );
endmodule
